// File: rtl/axis_rotate_pipe.sv
// AXI4-Stream lane rotator built as a registered log-shifter: stage j rotates by 2^j lanes.
// Control comes from tuser per beat, or is latched at packet start when PACKET_MODE is set.
module axis_rotate_pipe #(
   parameter int DATA_WIDTH  = 32,
   parameter int LANE_WIDTH  = 8,
   parameter int TUSER_WIDTH = 8,
   parameter int PACKET_MODE = 0
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic [TUSER_WIDTH-1:0]    s_axis_tuser,
   input  logic                      s_axis_tlast,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic [TUSER_WIDTH-1:0]    m_axis_tuser,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready
);

   localparam int N       = DATA_WIDTH / LANE_WIDTH;
   localparam int KW      = DATA_WIDTH / 8;
   localparam int KL      = LANE_WIDTH / 8;
   localparam int AMT_W   = (N > 1) ? $clog2(N) : 1;
   localparam int LATENCY = AMT_W;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_IN_PKT = 1'b1;

   function automatic logic [AMT_W-1:0] amt_of(input logic [TUSER_WIDTH-1:0] u);
      logic [31:0] t;
      t = 32'(u[AMT_W-1:0]) % 32'(N);
      return t[AMT_W-1:0];
   endfunction

   // Left moves lane i to lane i+sh (toward the MSB); right is the inverse.
   function automatic logic [DATA_WIDTH-1:0] rot_data(input logic [DATA_WIDTH-1:0] d,
                                                      input int sh, input logic right);
      logic [DATA_WIDTH-1:0] r;
      int src;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (right) begin
            src = (i + sh) % N;
         end else begin
            src = (i + N - sh) % N;
         end
         r[i*LANE_WIDTH +: LANE_WIDTH] = d[src*LANE_WIDTH +: LANE_WIDTH];
      end
      return r;
   endfunction

   function automatic logic [KW-1:0] rot_keep(input logic [KW-1:0] k,
                                              input int sh, input logic right);
      logic [KW-1:0] r;
      int src;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (right) begin
            src = (i + sh) % N;
         end else begin
            src = (i + N - sh) % N;
         end
         r[i*KL +: KL] = k[src*KL +: KL];
      end
      return r;
   endfunction

   logic [0:0]             state_q, state_d;
   logic [TUSER_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [TUSER_WIDTH-1:0] eff_ctrl_s;
   logic                   in_hs_s;

   logic [LATENCY-1:0]     vld_q;
   logic [LATENCY-1:0]     last_q;
   logic [LATENCY-1:0]     rdy_s;
   logic [DATA_WIDTH-1:0]  data_q [LATENCY];
   logic [KW-1:0]          keep_q [LATENCY];
   logic [TUSER_WIDTH-1:0] user_q [LATENCY];
   logic [AMT_W-1:0]       amt_q  [LATENCY];

   logic [LATENCY-1:0]     in_vld_s;
   logic [LATENCY-1:0]     in_last_s;
   logic [DATA_WIDTH-1:0]  in_data_s [LATENCY];
   logic [KW-1:0]          in_keep_s [LATENCY];
   logic [TUSER_WIDTH-1:0] in_user_s [LATENCY];
   logic [AMT_W-1:0]       in_amt_s  [LATENCY];
   logic [DATA_WIDTH-1:0]  data_d    [LATENCY];
   logic [KW-1:0]          keep_d    [LATENCY];

   // Ready chain computed from the output side back; a bubble anywhere downstream frees a stage.
   always_comb begin
      logic acc;
      acc = m_axis_tready;
      for (int j = LATENCY - 1; j >= 0; j--) begin
         acc      = acc || !vld_q[j];
         rdy_s[j] = acc;
      end
      s_axis_tready = aresetn && rdy_s[0];
      in_hs_s       = s_axis_tvalid && s_axis_tready;
   end

   // Effective control and packet FSM next state.
   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      if ((PACKET_MODE != 0) && (state_q == ST_IN_PKT)) begin
         eff_ctrl_s = ctrl_q;
      end else begin
         eff_ctrl_s = s_axis_tuser;
      end
      if ((PACKET_MODE != 0) && in_hs_s) begin
         case (state_q)
            ST_IDLE: begin
               if (!s_axis_tlast) begin
                  state_d = ST_IN_PKT;
                  ctrl_d  = s_axis_tuser;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_IN_PKT: begin
               if (s_axis_tlast) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_IN_PKT;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Stage inputs and the conditional per-stage rotation.
   always_comb begin
      in_vld_s[0]  = s_axis_tvalid;
      in_last_s[0] = s_axis_tlast;
      in_data_s[0] = s_axis_tdata;
      in_keep_s[0] = s_axis_tkeep;
      in_user_s[0] = eff_ctrl_s;
      in_amt_s[0]  = amt_of(eff_ctrl_s);
      for (int j = 1; j < LATENCY; j++) begin
         in_vld_s[j]  = vld_q[j-1];
         in_last_s[j] = last_q[j-1];
         in_data_s[j] = data_q[j-1];
         in_keep_s[j] = keep_q[j-1];
         in_user_s[j] = user_q[j-1];
         in_amt_s[j]  = amt_q[j-1];
      end
      for (int j = 0; j < LATENCY; j++) begin
         if (in_amt_s[j][j]) begin
            data_d[j] = rot_data(in_data_s[j], (1 << j) % N, in_user_s[j][TUSER_WIDTH-1]);
            keep_d[j] = rot_keep(in_keep_s[j], (1 << j) % N, in_user_s[j][TUSER_WIDTH-1]);
         end else begin
            data_d[j] = in_data_s[j];
            keep_d[j] = in_keep_s[j];
         end
      end
   end

   // Pipeline and packet state registers; payload only moves with a valid beat.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
         ctrl_q  <= '0;
         vld_q   <= '0;
         last_q  <= '0;
         for (int j = 0; j < LATENCY; j++) begin
            data_q[j] <= '0;
            keep_q[j] <= '0;
            user_q[j] <= '0;
            amt_q[j]  <= '0;
         end
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         for (int j = 0; j < LATENCY; j++) begin
            if (rdy_s[j]) begin
               vld_q[j] <= in_vld_s[j];
               if (in_vld_s[j]) begin
                  last_q[j] <= in_last_s[j];
                  data_q[j] <= data_d[j];
                  keep_q[j] <= keep_d[j];
                  user_q[j] <= in_user_s[j];
                  amt_q[j]  <= in_amt_s[j];
               end
            end
         end
      end
   end

   assign m_axis_tvalid = vld_q[LATENCY-1];
   assign m_axis_tlast  = last_q[LATENCY-1];
   assign m_axis_tdata  = data_q[LATENCY-1];
   assign m_axis_tkeep  = keep_q[LATENCY-1];
   assign m_axis_tuser  = user_q[LATENCY-1];

endmodule

// File: tb/tb_axis_rotate_pipe.sv
// Bench for axis_rotate_pipe: one per-beat instance and one packet-mode instance,
// table-driven vectors plus hand-written backpressure and reset sequences, scoreboarded.
module tb_axis_rotate_pipe;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic [7:0]  user;
      logic        last;
   } beat_t;

   typedef struct {
      beat_t in;
      beat_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   hs_cyc = 0;
   int   checks = 0;
   int   failures = 0;

   logic [31:0] s0_tdata, s1_tdata, m0_tdata, m1_tdata;
   logic [3:0]  s0_tkeep, s1_tkeep, m0_tkeep, m1_tkeep;
   logic [7:0]  s0_tuser, s1_tuser, m0_tuser, m1_tuser;
   logic        s0_tlast, s1_tlast, m0_tlast, m1_tlast;
   logic        s0_tvalid, s1_tvalid, m0_tvalid, m1_tvalid;
   logic        s0_tready, s1_tready, m0_tready, m1_tready;

   beat_t out0, out1, hold0, hold1;
   bit    stall0, stall1;
   beat_t q0[$];
   beat_t q1[$];
   vec_t  tbl [8];
   vec_t  pkt [6];

   assign out0 = {m0_tdata, m0_tkeep, m0_tuser, m0_tlast};
   assign out1 = {m1_tdata, m1_tkeep, m1_tuser, m1_tlast};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axis_rotate_pipe #(.DATA_WIDTH(32), .LANE_WIDTH(8), .TUSER_WIDTH(8), .PACKET_MODE(0)) dut0 (
      .aclk(clk), .aresetn(rst_n),
      .s_axis_tdata(s0_tdata), .s_axis_tkeep(s0_tkeep), .s_axis_tuser(s0_tuser),
      .s_axis_tlast(s0_tlast), .s_axis_tvalid(s0_tvalid), .s_axis_tready(s0_tready),
      .m_axis_tdata(m0_tdata), .m_axis_tkeep(m0_tkeep), .m_axis_tuser(m0_tuser),
      .m_axis_tlast(m0_tlast), .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready));

   axis_rotate_pipe #(.DATA_WIDTH(32), .LANE_WIDTH(8), .TUSER_WIDTH(8), .PACKET_MODE(1)) dut1 (
      .aclk(clk), .aresetn(rst_n),
      .s_axis_tdata(s1_tdata), .s_axis_tkeep(s1_tkeep), .s_axis_tuser(s1_tuser),
      .s_axis_tlast(s1_tlast), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
      .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tuser(m1_tuser),
      .m_axis_tlast(m1_tlast), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready));

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k,
                                input logic [7:0] u, input logic l);
      beat_t b;
      b.data = d; b.keep = k; b.user = u; b.last = l;
      return b;
   endfunction

   // Reference rotation via doubled-word shifts, independent of lane loops.
   function automatic beat_t model(input beat_t b, input logic [7:0] eff);
      logic [63:0] dd;
      logic [7:0]  kk;
      int          k;
      beat_t       r;
      k  = int'(eff[1:0]);
      dd = {b.data, b.data};
      kk = {b.keep, b.keep};
      if (eff[7]) begin
         dd = dd >> (8 * k);
         kk = kk >> k;
         r.data = dd[31:0];
         r.keep = kk[3:0];
      end else begin
         dd = dd << (8 * k);
         kk = kk << k;
         r.data = dd[63:32];
         r.keep = kk[7:4];
      end
      r.user = eff;
      r.last = b.last;
      return r;
   endfunction

   // Output monitors: scoreboard compare on handshake, stability check while stalled.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall0 <= 1'b0;
      end else begin
         if (stall0) check("hold0", 64'(out0), 64'(hold0));
         if (m0_tvalid && m0_tready) begin
            if (q0.size() == 0) begin
               checks++; failures++;
               $display("FAIL beat0: unexpected output %h", out0);
            end else begin
               check("beat0", 64'(out0), 64'(q0.pop_front()));
            end
         end
         stall0 <= m0_tvalid && !m0_tready;
         hold0  <= out0;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         stall1 <= 1'b0;
      end else begin
         if (stall1) check("hold1", 64'(out1), 64'(hold1));
         if (m1_tvalid && m1_tready) begin
            if (q1.size() == 0) begin
               checks++; failures++;
               $display("FAIL beat1: unexpected output %h", out1);
            end else begin
               check("beat1", 64'(out1), 64'(q1.pop_front()));
            end
         end
         stall1 <= m1_tvalid && !m1_tready;
         hold1  <= out1;
      end
   end

   task automatic send(input int which, input beat_t b, input beat_t e);
      bit done;
      done = 1'b0;
      if (which == 0) begin
         s0_tdata = b.data; s0_tkeep = b.keep; s0_tuser = b.user; s0_tlast = b.last;
         s0_tvalid = 1'b1;
      end else begin
         s1_tdata = b.data; s1_tkeep = b.keep; s1_tuser = b.user; s1_tlast = b.last;
         s1_tvalid = 1'b1;
      end
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         if ((which == 0 && s0_tready) || (which == 1 && s1_tready)) begin
            done   = 1'b1;
            hs_cyc = cyc;
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
         end
      end
      @(posedge clk); #1;
      if (which == 0) s0_tvalid = 1'b0;
      else            s1_tvalid = 1'b0;
      if (!done) begin
         checks++; failures++;
         $display("FAIL send%0d: no handshake within bound", which);
      end
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 60 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clk);
      check("drain", 64'(q0.size() + q1.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      tbl[0] = '{in: mk(32'h12345678, 4'hF, 8'h02, 1'b1), exp: mk(32'h56781234, 4'hF, 8'h02, 1'b1)};
      tbl[1] = '{in: mk(32'hAABBCCDD, 4'h3, 8'h81, 1'b0), exp: mk(32'hDDAABBCC, 4'h9, 8'h81, 1'b0)};
      tbl[2] = '{in: mk(32'hCAFEF00D, 4'hF, 8'h04, 1'b1), exp: mk(32'hCAFEF00D, 4'hF, 8'h04, 1'b1)};
      tbl[3] = '{in: mk(32'hCAFEF00D, 4'hF, 8'h00, 1'b0), exp: mk(32'hCAFEF00D, 4'hF, 8'h00, 1'b0)};
      tbl[4] = '{in: mk(32'h11223344, 4'hF, 8'h05, 1'b1), exp: mk(32'h22334411, 4'hF, 8'h05, 1'b1)};
      tbl[5] = '{in: mk(32'h11223344, 4'h1, 8'h83, 1'b0), exp: mk(32'h22334411, 4'h2, 8'h83, 1'b0)};
      tbl[6] = '{in: mk(32'hDEADBEEF, 4'h8, 8'h7D, 1'b1), exp: mk(32'hADBEEFDE, 4'h1, 8'h7D, 1'b1)};
      tbl[7] = '{in: mk(32'h01020304, 4'h6, 8'h82, 1'b0), exp: mk(32'h03040102, 4'h9, 8'h82, 1'b0)};
      pkt[0] = '{in: mk(32'h11223344, 4'hF, 8'h01, 1'b0), exp: mk(32'h22334411, 4'hF, 8'h01, 1'b0)};
      pkt[1] = '{in: mk(32'h11223344, 4'hF, 8'h03, 1'b0), exp: mk(32'h22334411, 4'hF, 8'h01, 1'b0)};
      pkt[2] = '{in: mk(32'h11223344, 4'hF, 8'h82, 1'b1), exp: mk(32'h22334411, 4'hF, 8'h01, 1'b1)};
      pkt[3] = '{in: mk(32'h11223344, 4'hF, 8'h81, 1'b1), exp: mk(32'h44112233, 4'hF, 8'h81, 1'b1)};
      pkt[4] = '{in: mk(32'hAABBCCDD, 4'h3, 8'h02, 1'b0), exp: mk(32'hCCDDAABB, 4'hC, 8'h02, 1'b0)};
      pkt[5] = '{in: mk(32'hAABBCCDD, 4'h3, 8'h81, 1'b1), exp: mk(32'hCCDDAABB, 4'hC, 8'h02, 1'b1)};

      rst_n = 1'b0;
      s0_tdata = '0; s0_tkeep = '0; s0_tuser = '0; s0_tlast = 1'b0; s0_tvalid = 1'b0;
      s1_tdata = '0; s1_tkeep = '0; s1_tuser = '0; s1_tlast = 1'b0; s1_tvalid = 1'b0;
      m0_tready = 1'b1; m1_tready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_s_tready0", 64'(s0_tready), 64'd0);
      check("rst_m_tvalid0", 64'(m0_tvalid), 64'd0);
      check("rst_out0", 64'(out0), 64'd0);
      check("rst_m_tvalid1", 64'(m1_tvalid), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_s_tready0", 64'(s0_tready), 64'd1);
      check("post_rst_s_tready1", 64'(s1_tready), 64'd1);
      @(posedge clk); #1;

      // Single beat latency.
      send(0, tbl[0].in, tbl[0].exp);
      for (int n = 0; n < 10 && !m0_tvalid; n++) @(negedge clk);
      check("latency", 64'(cyc - hs_cyc), 64'd2);
      wait_drain();

      for (int i = 1; i < 8; i++) send(0, tbl[i].in, tbl[i].exp);
      wait_drain();

      // Backpressure: three-cycle output stall mid-stream.
      fork
         begin
            for (int i = 1; i <= 4; i++) begin
               send(0, mk(32'(i), 4'hF, 8'h01, 1'(i == 4)),
                    model(mk(32'(i), 4'hF, 8'h01, 1'(i == 4)), 8'h01));
            end
         end
         begin
            for (int n = 0; n < 20 && !m0_tvalid; n++) @(negedge clk);
            @(posedge clk); #1;
            m0_tready = 1'b0;
            repeat (3) @(negedge clk);
            check("bp_s_tready_low", 64'(s0_tready), 64'd0);
            check("bp_m_tvalid_held", 64'(m0_tvalid), 64'd1);
            @(posedge clk); #1;
            m0_tready = 1'b1;
            @(negedge clk);
            check("bp_s_tready_resume", 64'(s0_tready), 64'd1);
         end
      join
      wait_drain();

      for (int i = 0; i < 6; i++) send(1, pkt[i].in, pkt[i].exp);
      wait_drain();

      // Reset while a packet is open and its first beat is still inside.
      m1_tready = 1'b0;
      send(1, mk(32'h11223344, 4'hF, 8'h01, 1'b0), mk(32'h22334411, 4'hF, 8'h01, 1'b0));
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_out1", 64'(out1), 64'd0);
      check("midrst_m_tvalid1", 64'(m1_tvalid), 64'd0);
      check("midrst_s_tready1", 64'(s1_tready), 64'd0);
      check("midrst_out0", 64'(out0), 64'd0);
      q1.delete();
      m1_tready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(1, mk(32'h11223344, 4'hF, 8'h82, 1'b0), mk(32'h33441122, 4'hF, 8'h82, 1'b0));
      send(1, mk(32'h11223344, 4'hF, 8'h01, 1'b1), mk(32'h33441122, 4'hF, 8'h82, 1'b1));
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_rotate_pipe.md
Name: axis_rotate_pipe

Overview:
Pipelined, parametrised AXI4-Stream lane rotator. It rotates each beat's tdata and tkeep left or right by a whole number of lanes, with the lane size set by a parameter. The rotation control comes from tuser, either per beat or latched once per packet. It sits inline on the stream datapath, runs at full throughput with backpressure, and replaces the single-stage byte rotator.

Parameters:
DATA_WIDTH, 32, tdata width; must be a multiple of LANE_WIDTH.
LANE_WIDTH, 8, rotation granularity in bits; must be a multiple of 8.
TUSER_WIDTH, 8, control width. The MSB is the direction (1 = right, 0 = left). The low AMT_W bits are the amount in lanes.
PACKET_MODE, 0, 0 = control taken per beat; 1 = control latched on the first beat and held until tlast.
Derived: N = DATA_WIDTH/LANE_WIDTH; AMT_W = max(1, clog2(N)); LATENCY = max(1, clog2(N)).

Ports:
aclk  in  1  clock, rising edge
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  DATA_WIDTH  input data
s_axis_tkeep  in  DATA_WIDTH/8  input byte enables
s_axis_tuser  in  TUSER_WIDTH  rotation control
s_axis_tlast  in  1  end of packet
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_WIDTH  rotated data
m_axis_tkeep  out  DATA_WIDTH/8  rotated byte enables
m_axis_tuser  out  TUSER_WIDTH  effective control applied to this beat
m_axis_tlast  out  1  end of packet, passed through
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready

Behaviour:
- Reset: asserting aresetn low clears the following asynchronously, including mid-packet:
  - all stage valids
  - m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser and m_axis_tlast (all to 0)
  - packet state (to IDLE) and the latched control (to 0).
- s_axis_tready is 0 while aresetn is low.
- Amount and direction:
  - k = tuser[AMT_W-1:0] mod N.
  - Left rotate by k gives tdata rotated toward the MSB by k*LANE_WIDTH bits; the top lanes wrap to the bottom.
  - Right rotate is the inverse.
  - tkeep rotates by k*LANE_WIDTH/8 bits in the same direction.
  - k = 0 passes data and keep unchanged. Amounts of N or more wrap modulo N.
  - Unused tuser bits between AMT_W and the MSB are ignored for the rotation but are forwarded.
- Pipeline: LATENCY register stages form a log-shifter.
  - Stage j rotates by 2^j lanes when amount bit j is set.
  - Each stage carries a valid flag plus data, keep, control and tlast.
  - Stage ready: rdy_j = !vld_j || rdy_(j+1); the last stage uses m_axis_tready. s_axis_tready = rdy_0.
  - A stage loads whenever its rdy is 1; bubbles collapse.
  - Throughput is 1 beat/cycle. Latency is LATENCY cycles from the input handshake to m_axis_tvalid with no stall.
- Handshake rules:
  - m_axis_* are stable while m_axis_tvalid=1 and m_axis_tready=0.
  - Beats are never dropped, duplicated or reordered.
  - When the pipeline is full and m_axis_tready=0, s_axis_tready=0.
  - A simultaneous output handshake and input handshake in one cycle is legal; occupancy is unchanged.
- PACKET_MODE=1 control FSM. Effective control updates only on an input handshake.
  - IDLE: a beat uses its own tuser.
    - If tlast=0: latch tuser, go to IN_PKT.
    - If tlast=1 (single-beat packet): stay in IDLE.
  - IN_PKT: beats use the latched control; s_axis_tuser is ignored.
    - The handshake of the tlast beat returns the FSM to IDLE.
- PACKET_MODE=0: every beat uses its own tuser and the FSM is absent.
- m_axis_tuser equals the effective control applied to that beat.
- Reset mid-packet: any partial packet is discarded. The next beat after reset is treated as a packet start.

Test Plan:
- Left rotate (N=4, LATENCY=2, m_axis_tready=1): tdata=0x12345678, tuser=0x02, tkeep=0xF -> m_axis_tdata=0x56781234, tkeep=0xF, 2 cycles after the handshake.
- Right rotate and keep: tdata=0xAABBCCDD, tuser=0x81, tkeep=0x3 -> m_axis_tdata=0xDDAABBCC, m_axis_tkeep=0x9, m_axis_tuser=0x81.
- Wrap and zero amount: tuser=0x04, then 0x00, on 0xCAFEF00D -> 0xCAFEF00D both times. tuser=0x05 on 0x11223344 -> 0x22334411.
- Backpressure: stream 0x1,0x2,0x3,0x4 back-to-back with m_axis_tready low for 3 cycles mid-stream -> s_axis_tready drops once 2 beats are held; output values hold stable; all 4 beats exit in order; full rate resumes.
- Packet mode (PACKET_MODE=1): a 3-beat packet with tuser 0x01, 0x03, 0x82 and data 0x11223344 on every beat -> all three outputs are 0x22334411 with m_axis_tuser=0x01. The next packet with tuser=0x81 gives 0x44112233.
- Reset mid-packet: drop aresetn after beat 1 of a 3-beat packet, then release -> outputs are 0 during reset. The next beat's own tuser is applied and the FSM is in IDLE.
